// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready streaming.
// Stage 1 registers per-group propagate/generate; stage 2 resolves carries and registers sum/flags.
module cla_adder_pipe #(
   parameter int WIDTH = 16,
   parameter int GRP   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             zero
);

   localparam int NG = WIDTH / GRP;

   generate
      if (GRP != 4 || (WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_bad_param
         $error("cla_adder_pipe: GRP must be 4 and WIDTH a multiple of 4 in 4..64");
      end
   endgenerate

   // Flat lookahead carry out of position k: OR of each generate term ANDed with every
   // propagate above it, plus the carry-in ANDed with all propagates 0..k.
   function automatic logic la_carry(input logic [15:0] gen, input logic [15:0] prop,
                                     input logic cin, input int k);
      logic acc;
      logic term;
      acc = 1'b0;
      for (int j = 0; j < 16; j++) begin
         if (j <= k) begin
            term = gen[j];
            for (int m = 0; m < 16; m++) begin
               if (m > j && m <= k) term = term & prop[m];
            end
            acc = acc | term;
         end
      end
      term = cin;
      for (int m = 0; m < 16; m++) begin
         if (m <= k) term = term & prop[m];
      end
      return acc | term;
   endfunction

   // Handshake: a beat moves on valid & ready at a rising edge. A stage advances when it is
   // empty or its contents leave this cycle; in_ready never depends on in_valid.
   logic s2_adv;
   logic s1_adv;
   logic s1_valid;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = rst_n && s1_adv;

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] p_d;
   logic [WIDTH-1:0] g_d;
   logic [NG-1:0]    pg_d;
   logic [NG-1:0]    gg_d;

   always_comb begin
      b_eff = op_sub ? ~b : b;
      p_d   = a ^ b_eff;
      g_d   = a & b_eff;
      pg_d  = '0;
      gg_d  = '0;
      for (int g = 0; g < NG; g++) begin
         pg_d[g] = &p_d[g*4 +: 4];
         gg_d[g] = la_carry({12'd0, g_d[g*4 +: 4]}, {12'd0, p_d[g*4 +: 4]}, 1'b0, 3);
      end
   end

   logic [WIDTH-1:0] s1_p;
   logic [WIDTH-1:0] s1_g;
   logic [NG-1:0]    s1_pg;
   logic [NG-1:0]    s1_gg;
   logic             s1_cin;

   logic [15:0]      pg_x;
   logic [15:0]      gg_x;
   logic [NG:0]      gc;
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] sum_d;
   logic             c_out_d;
   logic             ovf_d;
   logic             zero_d;

   always_comb begin
      pg_x           = '0;
      gg_x           = '0;
      pg_x[NG-1:0]   = s1_pg;
      gg_x[NG-1:0]   = s1_gg;
      gc             = '0;
      gc[0]          = s1_cin;
      for (int k = 0; k < NG; k++) begin
         gc[k+1] = la_carry(gg_x, pg_x, s1_cin, k);
      end
      carry = '0;
      for (int g = 0; g < NG; g++) begin
         for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
               carry[g*4] = gc[g];
            end else begin
               carry[g*4+i] = la_carry({12'd0, s1_g[g*4 +: 4]}, {12'd0, s1_p[g*4 +: 4]},
                                       gc[g], i - 1);
            end
         end
      end
      sum_d   = s1_p ^ carry;
      c_out_d = gc[NG];
      ovf_d   = carry[WIDTH-1] ^ gc[NG];
      zero_d  = (sum_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_p      <= '0;
         s1_g      <= '0;
         s1_pg     <= '0;
         s1_gg     <= '0;
         s1_cin    <= 1'b0;
         out_valid <= 1'b0;
         sum       <= '0;
         c_out     <= 1'b0;
         ovf       <= 1'b0;
         zero      <= 1'b0;
      end else begin
         if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
               s1_p   <= p_d;
               s1_g   <= g_d;
               s1_pg  <= pg_d;
               s1_gg  <= gg_d;
               s1_cin <= c_in;
            end
         end
         // Result registers only load with a real beat so held data stays stable.
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               sum   <= sum_d;
               c_out <= c_out_d;
               ovf   <= ovf_d;
               zero  <= zero_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: three widths share one stimulus stream, each with its own
// expected-result queue fed from a behavioural arithmetic model.
module tb_cla_adder_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        c_in = 1'b0;
   logic        op_sub = 1'b0;
   logic        out_ready = 1'b0;
   logic [63:0] a = '0;
   logic [63:0] b = '0;

   always #5 clk = ~clk;

   logic        in_ready4, out_valid4, c_out4, ovf4, zero4;
   logic [3:0]  sum4;
   logic        in_ready16, out_valid16, c_out16, ovf16, zero16;
   logic [15:0] sum16;
   logic        in_ready64, out_valid64, c_out64, ovf64, zero64;
   logic [63:0] sum64;

   cla_adder_pipe #(.WIDTH(4), .GRP(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
      .a(a[3:0]), .b(b[3:0]), .c_in(c_in), .op_sub(op_sub),
      .out_valid(out_valid4), .out_ready(out_ready), .sum(sum4),
      .c_out(c_out4), .ovf(ovf4), .zero(zero4));

   cla_adder_pipe #(.WIDTH(16), .GRP(4)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
      .a(a[15:0]), .b(b[15:0]), .c_in(c_in), .op_sub(op_sub),
      .out_valid(out_valid16), .out_ready(out_ready), .sum(sum16),
      .c_out(c_out16), .ovf(ovf16), .zero(zero16));

   cla_adder_pipe #(.WIDTH(64), .GRP(4)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
      .a(a), .b(b), .c_in(c_in), .op_sub(op_sub),
      .out_valid(out_valid64), .out_ready(out_ready), .sum(sum64),
      .c_out(c_out64), .ovf(ovf64), .zero(zero64));

   int          checks = 0;
   int          failures = 0;
   logic [66:0] exp_q4[$];
   logic [66:0] exp_q16[$];
   logic [66:0] exp_q64[$];
   logic [15:0] got_q16[$];
   logic        fire16 = 1'b0;

   task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Result packed as {c_out, ovf, zero, sum}
   function automatic logic [66:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                         input logic ci, input logic sub);
      logic [64:0] mask, lmask, xm, ym, full, low;
      logic [63:0] s;
      logic        co, cm;
      mask  = (65'd1 << w) - 65'd1;
      lmask = (65'd1 << (w - 1)) - 65'd1;
      xm    = {1'b0, x} & mask;
      ym    = (sub ? {1'b0, ~y} : {1'b0, y}) & mask;
      full  = xm + ym + 65'(ci);
      low   = (xm & lmask) + (ym & lmask) + 65'(ci);
      co    = full[w];
      cm    = low[w-1];
      s     = full[63:0] & mask[63:0];
      return {co, cm ^ co, s == 64'd0, s};
   endfunction

   function automatic logic [66:0] res16();
      return {c_out16, ovf16, zero16, 64'(sum16)};
   endfunction

   task automatic monitor();
      fire16 = in_valid && in_ready16;
      if (in_valid && in_ready4)  exp_q4.push_back(model(4, a, b, c_in, op_sub));
      if (in_valid && in_ready16) exp_q16.push_back(model(16, a, b, c_in, op_sub));
      if (in_valid && in_ready64) exp_q64.push_back(model(64, a, b, c_in, op_sub));
      if (out_valid4 && out_ready) begin
         if (exp_q4.size() == 0) check("sb4_empty", 67'd1, 67'd0);
         else check("sb4", {c_out4, ovf4, zero4, 64'(sum4)}, exp_q4.pop_front());
      end
      if (out_valid16 && out_ready) begin
         got_q16.push_back(sum16);
         if (exp_q16.size() == 0) check("sb16_empty", 67'd1, 67'd0);
         else check("sb16", res16(), exp_q16.pop_front());
      end
      if (out_valid64 && out_ready) begin
         if (exp_q64.size() == 0) check("sb64_empty", 67'd1, 67'd0);
         else check("sb64", {c_out64, ovf64, zero64, sum64}, exp_q64.pop_front());
      end
   endtask

   // Called just after a falling edge: observe one time unit before the rising edge.
   task automatic tick();
      #4;
      monitor();
      @(negedge clk);
   endtask

   task automatic run_dir(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input logic sub, input logic [66:0] exp);
      a = 64'(x); b = 64'(y); c_in = ci; op_sub = sub;
      in_valid = 1'b1; out_ready = 1'b1;
      check({tag, "_in_ready"}, 67'(in_ready16), 67'd1);
      tick();
      in_valid = 1'b0;
      check({tag, "_lat1"}, 67'(out_valid16), 67'd0);
      tick();
      check({tag, "_lat2"}, 67'(out_valid16), 67'd1);
      check({tag, "_res"}, res16(), exp);
      tick();
   endtask

   initial begin
      int sent;
      int cyc;
      logic accepted;

      // Reset state
      @(negedge clk);
      #1;
      check("rst_in_ready", 67'(in_ready16), 67'd0);
      check("rst_out", res16(), 67'd0);
      check("rst_out_valid", 67'(out_valid16), 67'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", 67'(in_ready16), 67'd1);
      @(negedge clk);

      // Directed arithmetic corners
      run_dir("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 64'h0000});
      run_dir("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 64'h8000});
      run_dir("sub_ovf",  16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 1'b0, 64'h7FFF});
      run_dir("sub_neg",  16'h0003, 16'h0005, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, 64'hFFFE});

      // Stall with both stages full, then release
      got_q16.delete();
      out_ready = 1'b0; c_in = 1'b0; op_sub = 1'b0;
      in_valid = 1'b1; a = 64'd1; b = 64'd1;
      tick();
      a = 64'd2; b = 64'd2;
      tick();
      a = 64'd3; b = 64'd3;
      check("stall_in_ready", 67'(in_ready16), 67'd0);
      check("stall_out_valid", 67'(out_valid16), 67'd1);
      check("stall_hold1", 67'(sum16), 67'h2);
      tick();
      check("stall_hold2", 67'(sum16), 67'h2);
      out_ready = 1'b1;
      accepted = 1'b0;
      for (int i = 0; i < 10 && !accepted; i++) begin
         tick();
         accepted = fire16;
      end
      if (!accepted) check("stall_accept_timeout", 67'd0, 67'd1);
      in_valid = 1'b0;
      for (int i = 0; i < 10 && got_q16.size() < 3; i++) tick();
      check("stall_count", 67'(got_q16.size()), 67'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < got_q16.size()) check("stall_order", 67'(got_q16[i]), 67'(2 * (i + 1)));
      end

      // Reset with beats in flight
      out_ready = 1'b0;
      in_valid = 1'b1; a = 64'h5; b = 64'h6;
      tick();
      a = 64'h7; b = 64'h8;
      tick();
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("flight_out_valid16", 67'(out_valid16), 67'd0);
      check("flight_out16", res16(), 67'd0);
      check("flight_in_ready", 67'(in_ready16), 67'd0);
      check("flight_out_valid4", 67'(out_valid4), 67'd0);
      check("flight_out64", {c_out64, ovf64, zero64, sum64}, 67'd0);
      exp_q4.delete(); exp_q16.delete(); exp_q64.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("flight_rel_in_ready", 67'(in_ready16), 67'd1);
      @(negedge clk);

      // Random traffic on all widths
      sent = 0;
      cyc = 0;
      fire16 = 1'b0;
      while (sent < 10000 && cyc < 60000) begin
         if (!in_valid || fire16) begin
            if ($urandom_range(0, 9) < 8) begin
               in_valid = 1'b1;
               case ($urandom_range(0, 7))
                  0: a = '1;
                  1: a = '0;
                  default: a = {$urandom(), $urandom()};
               endcase
               case ($urandom_range(0, 7))
                  0: b = '1;
                  1: b = 64'd1;
                  default: b = {$urandom(), $urandom()};
               endcase
               c_in   = 1'($urandom_range(0, 1));
               op_sub = 1'($urandom_range(0, 1));
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 9) < 7);
         tick();
         cyc++;
         if (fire16) sent++;
      end
      if (sent < 10000) check("rand_sent_timeout", 67'(sent), 67'd10000);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (exp_q4.size() != 0 || exp_q16.size() != 0 || exp_q64.size() != 0) tick();
      end
      check("drain4", 67'(exp_q4.size()), 67'd0);
      check("drain16", 67'(exp_q16.size()), 67'd0);
      check("drain64", 67'(exp_q64.size()), 67'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
